// File: rtl/wb_register_file.sv
// Write-back receiving register file for the 16-bit MIPS pipeline.
// Two combinational read ports with same-cycle bypass and a pending-write scoreboard.
module wb_register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_use,
  input  logic              rt_use,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic [NREGS-1:0]  pending
);

  // Register 0 is hardwired to zero, so no storage exists for it.
  logic [DATA_W-1:0] r_regs [NREGS-1:1];
  logic [NREGS-1:1]  r_pend;

  logic [NREGS-1:0]  w_wb_hit;
  logic [NREGS-1:0]  w_iss_hit;
  logic [NREGS-1:0]  w_pend_all;
  logic [NREGS-1:0]  w_pend_eff;
  logic [DATA_W-1:0] w_rs_reg;
  logic [DATA_W-1:0] w_rt_reg;
  logic              w_rs_byp;
  logic              w_rt_byp;
  logic              w_rs_haz;
  logic              w_rt_haz;
  logic              w_iss_ok;

  always_comb begin
    w_wb_hit  = '0;
    w_iss_hit = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_wb_hit[i]  = wb_en && (wb_addr == ADDR_W'(i));
      w_iss_hit[i] = w_iss_ok && (iss_dst == ADDR_W'(i));
    end
  end

  assign w_pend_all = {r_pend, 1'b0};
  // A write-back landing this cycle resolves the hazard immediately.
  assign w_pend_eff = w_pend_all & ~w_wb_hit;

  assign w_rs_haz = rs_use && w_pend_eff[rs_addr];
  assign w_rt_haz = rt_use && w_pend_eff[rt_addr];
  assign stall    = w_rs_haz || w_rt_haz;
  assign w_iss_ok = iss_en && !stall;
  assign pending  = w_pend_all;

  always_comb begin
    w_rs_reg = '0;
    w_rt_reg = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs_addr == ADDR_W'(i))
        w_rs_reg = r_regs[i];
      if (rt_addr == ADDR_W'(i))
        w_rt_reg = r_regs[i];
    end
  end

  assign w_rs_byp = w_wb_hit[rs_addr];
  assign w_rt_byp = w_wb_hit[rt_addr];

  always_comb begin
    rs_data = w_rs_reg;
    rt_data = w_rt_reg;
    if (w_rs_byp)
      rs_data = ans_wb;
    if (w_rt_byp)
      rt_data = ans_wb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (w_wb_hit[i])
          r_regs[i] <= ans_wb;
    end
  end

  // A new producer issuing this cycle outranks the retiring one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_iss_hit[i])
          r_pend[i] <= 1'b1;
        else if (w_wb_hit[i])
          r_pend[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Bench for wb_register_file: directed cases with literal expectations,
// then random traffic against a behavioural register/scoreboard model.
module tb_wb_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] ans_wb = '0;
  logic [2:0]  rs_addr = '0;
  logic [2:0]  rt_addr = '0;
  logic        rs_use = 1'b0;
  logic        rt_use = 1'b0;
  logic        iss_en = 1'b0;
  logic [2:0]  iss_dst = '0;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        stall;
  logic [7:0]  pending;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  int m_regs [8];
  bit m_pend [8];

  wb_register_file dut (
    .clk(clk), .reset(reset),
    .wb_en(wb_en), .wb_addr(wb_addr), .ans_wb(ans_wb),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_use(rs_use), .rt_use(rt_use),
    .iss_en(iss_en), .iss_dst(iss_dst),
    .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_read(int a);
    if (a == 0) return 0;
    if (wb_en && wb_addr == a) return ans_wb;
    return m_regs[a];
  endfunction

  function automatic bit m_eff(int r);
    return m_pend[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic bit m_stall();
    return (rs_use && m_eff(rs_addr)) || (rt_use && m_eff(rt_addr));
  endfunction

  function automatic logic [7:0] m_pvec();
    logic [7:0] v;
    for (int r = 0; r < 8; r++) v[r] = m_pend[r];
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 8; r++) begin
        m_regs[r] = 0;
        m_pend[r] = 0;
      end
    end else begin
      bit acc;
      acc = iss_en && !m_stall();
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] = ans_wb;
        m_pend[wb_addr] = 0;
      end
      if (acc && iss_dst != 0) m_pend[iss_dst] = 1;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_rs", 32'(rs_data), 32'(m_read(rs_addr)));
      chk("cmp_rt", 32'(rt_data), 32'(m_read(rt_addr)));
      chk("cmp_stall", 32'(stall), 32'(m_stall()));
      chk("cmp_pend", 32'(pending), 32'(m_pvec()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 0; iss_en = 0; rs_use = 0; rt_use = 0;
  endtask

  initial begin
    #2;
    chk("rst_pend", 32'(pending), 32'h00);
    chk("rst_rs", 32'(rs_data), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    #6 reset = 1'b1;
    run_cmp = 1'b1;
    step();
    rs_addr = 3; rt_addr = 5; #1;
    chk("post_rst_rs", 32'(rs_data), 32'h0);
    chk("post_rst_rt", 32'(rt_data), 32'h0);
    chk("post_rst_pend", 32'(pending), 32'h00);
    chk("post_rst_stall", 32'(stall), 32'h0);

    wb_en = 1; wb_addr = 2; ans_wb = 16'hBEEF;
    step();
    wb_en = 0; rs_addr = 2; #1;
    chk("wr_rd", 32'(rs_data), 32'hBEEF);
    wb_en = 1; wb_addr = 4; ans_wb = 16'h1234; rt_addr = 4; #1;
    chk("bypass", 32'(rt_data), 32'h1234);
    step();

    wb_en = 1; wb_addr = 0; ans_wb = 16'hFFFF; rs_addr = 0; #1;
    chk("r0_byp", 32'(rs_data), 32'h0);
    step();
    wb_en = 0; #1;
    chk("r0_rd", 32'(rs_data), 32'h0);
    iss_en = 1; iss_dst = 0;
    step();
    iss_en = 0; #1;
    chk("r0_iss", 32'(pending), 32'h00);

    iss_en = 1; iss_dst = 6;
    step();
    iss_en = 0; #1;
    chk("iss6", 32'(pending), 32'h40);
    rs_addr = 6; rs_use = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("haz_stall", 32'(stall), 32'h1);
      step();
    end
    wb_en = 1; wb_addr = 6; ans_wb = 16'h0A0A; #1;
    chk("haz_rel", 32'(stall), 32'h0);
    chk("haz_byp", 32'(rs_data), 32'h0A0A);
    step();
    idle(); #1;
    chk("haz_clr", 32'(pending), 32'h00);

    iss_en = 1; iss_dst = 5;
    step();
    #1 chk("p5_set", 32'(pending), 32'h20);
    wb_en = 1; wb_addr = 5; ans_wb = 16'h7777;
    step();
    idle(); rs_addr = 5; #1;
    chk("sim_pend", 32'(pending), 32'h20);
    chk("sim_data", 32'(rs_data), 32'h7777);
    wb_en = 1; wb_addr = 5; ans_wb = 16'h7777;
    step();

    wb_en = 1; wb_addr = 3; ans_wb = 16'h5555;
    step();
    wb_en = 0; iss_en = 1; iss_dst = 2;
    step();
    iss_dst = 3;
    step();
    iss_dst = 6;
    step();
    idle(); rs_addr = 3; #1;
    chk("pre_async_pend", 32'(pending), 32'h4C);
    chk("pre_async_rs", 32'(rs_data), 32'h5555);
    reset = 1'b0; #1;
    chk("async_pend", 32'(pending), 32'h00);
    chk("async_rs", 32'(rs_data), 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;

    for (int n = 0; n < 500; n++) begin
      step();
      wb_en   = ($urandom_range(0, 99) < 40);
      wb_addr = 3'($urandom);
      ans_wb  = 16'($urandom);
      rs_addr = 3'($urandom);
      rt_addr = 3'($urandom);
      rs_use  = $urandom_range(0, 1) == 1;
      rt_use  = $urandom_range(0, 1) == 1;
      iss_en  = ($urandom_range(0, 99) < 35);
      iss_dst = 3'($urandom);
    end
    step();
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
